// File: rtl/id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// id_ex_operand_stage : ID/EX pipeline register with MEM/WB operand forwarding
//                       and load-use bubble insertion.   Revision 1.0
// ============================================================================
module id_ex_operand_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              Stall_i,
  input  logic              Flush_i,
  input  logic              Valid_i,
  input  logic [CTRL_W-1:0] ALUCtrl_i,
  input  logic [DATA_W-1:0] RD1_i,
  input  logic [DATA_W-1:0] RD2_i,
  input  logic [DATA_W-1:0] ImmExt_i,
  input  logic [DATA_W-1:0] PC_i,
  input  logic [REG_AW-1:0] Rs1_i,
  input  logic [REG_AW-1:0] Rs2_i,
  input  logic [REG_AW-1:0] Rd_i,
  input  logic [1:0]        ASel_i,
  input  logic              BSel_i,
  input  logic              RegWrite_i,
  input  logic              MemRead_i,
  input  logic              MemRegWrite_i,
  input  logic [REG_AW-1:0] MemRd_i,
  input  logic [DATA_W-1:0] MemResult_i,
  input  logic              WbRegWrite_i,
  input  logic [REG_AW-1:0] WbRd_i,
  input  logic [DATA_W-1:0] WbResult_i,
  output logic [CTRL_W-1:0] ALUCtrl_o,
  output logic [DATA_W-1:0] SrcA_o,
  output logic [DATA_W-1:0] SrcB_o,
  output logic [DATA_W-1:0] WriteData_o,
  output logic [DATA_W-1:0] PC_o,
  output logic [REG_AW-1:0] Rd_o,
  output logic              RegWrite_o,
  output logic              MemRead_o,
  output logic              Valid_o,
  output logic              LoadUseHazard_o
);

  logic              valid_q,    valid_d;
  logic [CTRL_W-1:0] alu_ctrl_q, alu_ctrl_d;
  logic [DATA_W-1:0] rd1_q,      rd1_d;
  logic [DATA_W-1:0] rd2_q,      rd2_d;
  logic [DATA_W-1:0] imm_q,      imm_d;
  logic [DATA_W-1:0] pc_q,       pc_d;
  logic [REG_AW-1:0] rs1_q,      rs1_d;
  logic [REG_AW-1:0] rs2_q,      rs2_d;
  logic [REG_AW-1:0] rd_q,       rd_d;
  logic [1:0]        asel_q,     asel_d;
  logic              bsel_q,     bsel_d;
  logic              regwrite_q, regwrite_d;
  logic              memread_q,  memread_d;

  logic              hazard;
  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;

  assign hazard = valid_q & memread_q & (rd_q != '0) &
                  ((rd_q == Rs1_i) | (rd_q == Rs2_i)) & Valid_i;

  // Flush beats stall; a load-use bubble only happens when not stalled.
  always_comb begin
    valid_d    = valid_q;
    alu_ctrl_d = alu_ctrl_q;
    rd1_d      = rd1_q;
    rd2_d      = rd2_q;
    imm_d      = imm_q;
    pc_d       = pc_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    asel_d     = asel_q;
    bsel_d     = bsel_q;
    regwrite_d = regwrite_q;
    memread_d  = memread_q;
    if (Flush_i || (!Stall_i && hazard)) begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      memread_d  = 1'b0;
      rd_d       = '0;
    end else if (!Stall_i) begin
      valid_d    = Valid_i;
      alu_ctrl_d = ALUCtrl_i;
      rd1_d      = RD1_i;
      rd2_d      = RD2_i;
      imm_d      = ImmExt_i;
      pc_d       = PC_i;
      rs1_d      = Rs1_i;
      rs2_d      = Rs2_i;
      rd_d       = Rd_i;
      asel_d     = ASel_i;
      bsel_d     = BSel_i;
      regwrite_d = RegWrite_i & Valid_i;
      memread_d  = MemRead_i & Valid_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q    <= 1'b0;
      alu_ctrl_q <= '0;
      rd1_q      <= '0;
      rd2_q      <= '0;
      imm_q      <= '0;
      pc_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      asel_q     <= '0;
      bsel_q     <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      alu_ctrl_q <= alu_ctrl_d;
      rd1_q      <= rd1_d;
      rd2_q      <= rd2_d;
      imm_q      <= imm_d;
      pc_q       <= pc_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      asel_q     <= asel_d;
      bsel_q     <= bsel_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
    end
  end

  // MEM is younger than WB, so it wins; x0 never forwards.
  always_comb begin
    fwd_a = rd1_q;
    if (MemRegWrite_i && (MemRd_i != '0) && (MemRd_i == rs1_q))
      fwd_a = MemResult_i;
    else if (WbRegWrite_i && (WbRd_i != '0) && (WbRd_i == rs1_q))
      fwd_a = WbResult_i;

    fwd_b = rd2_q;
    if (MemRegWrite_i && (MemRd_i != '0) && (MemRd_i == rs2_q))
      fwd_b = MemResult_i;
    else if (WbRegWrite_i && (WbRd_i != '0) && (WbRd_i == rs2_q))
      fwd_b = WbResult_i;
  end

  always_comb begin
    SrcA_o = '0;
    case (asel_q)
      2'd0:    SrcA_o = fwd_a;
      2'd1:    SrcA_o = pc_q;
      default: SrcA_o = '0;
    endcase
  end

  assign SrcB_o          = bsel_q ? imm_q : fwd_b;
  assign WriteData_o     = fwd_b;
  assign ALUCtrl_o       = alu_ctrl_q;
  assign PC_o            = pc_q;
  assign Rd_o            = rd_q;
  assign RegWrite_o      = regwrite_q;
  assign MemRead_o       = memread_q;
  assign Valid_o         = valid_q;
  assign LoadUseHazard_o = hazard;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// tb_id_ex_operand_stage : directed self-checking bench for id_ex_operand_stage
//                          Revision 1.0
// ============================================================================
module tb_id_ex_operand_stage;

  logic        clk_i = 1'b0;
  logic        rst_i, Stall_i, Flush_i, Valid_i;
  logic [4:0]  ALUCtrl_i;
  logic [31:0] RD1_i, RD2_i, ImmExt_i, PC_i;
  logic [4:0]  Rs1_i, Rs2_i, Rd_i;
  logic [1:0]  ASel_i;
  logic        BSel_i, RegWrite_i, MemRead_i;
  logic        MemRegWrite_i;
  logic [4:0]  MemRd_i;
  logic [31:0] MemResult_i;
  logic        WbRegWrite_i;
  logic [4:0]  WbRd_i;
  logic [31:0] WbResult_i;
  logic [4:0]  ALUCtrl_o;
  logic [31:0] SrcA_o, SrcB_o, WriteData_o, PC_o;
  logic [4:0]  Rd_o;
  logic        RegWrite_o, MemRead_o, Valid_o, LoadUseHazard_o;

  int passed = 0;
  int total  = 0;

  always #5 clk_i = ~clk_i;

  id_ex_operand_stage #(.DATA_W(32), .REG_AW(5), .CTRL_W(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .Stall_i(Stall_i), .Flush_i(Flush_i),
    .Valid_i(Valid_i), .ALUCtrl_i(ALUCtrl_i), .RD1_i(RD1_i), .RD2_i(RD2_i),
    .ImmExt_i(ImmExt_i), .PC_i(PC_i), .Rs1_i(Rs1_i), .Rs2_i(Rs2_i),
    .Rd_i(Rd_i), .ASel_i(ASel_i), .BSel_i(BSel_i), .RegWrite_i(RegWrite_i),
    .MemRead_i(MemRead_i), .MemRegWrite_i(MemRegWrite_i), .MemRd_i(MemRd_i),
    .MemResult_i(MemResult_i), .WbRegWrite_i(WbRegWrite_i), .WbRd_i(WbRd_i),
    .WbResult_i(WbResult_i), .ALUCtrl_o(ALUCtrl_o), .SrcA_o(SrcA_o),
    .SrcB_o(SrcB_o), .WriteData_o(WriteData_o), .PC_o(PC_o), .Rd_o(Rd_o),
    .RegWrite_o(RegWrite_o), .MemRead_o(MemRead_o), .Valid_o(Valid_o),
    .LoadUseHazard_o(LoadUseHazard_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    rst_i = 0; Stall_i = 0; Flush_i = 0; Valid_i = 0;
    ALUCtrl_i = 0; RD1_i = 0; RD2_i = 0; ImmExt_i = 0; PC_i = 0;
    Rs1_i = 0; Rs2_i = 0; Rd_i = 0; ASel_i = 0; BSel_i = 0;
    RegWrite_i = 0; MemRead_i = 0;
    MemRegWrite_i = 0; MemRd_i = 0; MemResult_i = 0;
    WbRegWrite_i = 0; WbRd_i = 0; WbResult_i = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_i = 1;
    tick(); tick();
    rst_i = 0;
    Valid_i = 1; ALUCtrl_i = 5'd1; RD1_i = 32'd10; RD2_i = 32'd3;
    Rs1_i = 5'd1; Rs2_i = 5'd2; Rd_i = 5'd3; RegWrite_i = 1; PC_i = 32'h20;
    tick();
    total++; if (ALUCtrl_o !== 5'd1) $display("FAIL load_aluctrl: got %0d expected 1", ALUCtrl_o); else passed++;
    total++; if (SrcA_o !== 32'd10) $display("FAIL load_srca: got %0d expected 10", SrcA_o); else passed++;
    total++; if (SrcB_o !== 32'd3) $display("FAIL load_srcb: got %0d expected 3", SrcB_o); else passed++;
    total++; if (Valid_o !== 1'b1) $display("FAIL load_valid: got %b expected 1", Valid_o); else passed++;
    total++; if (Rd_o !== 5'd3 || RegWrite_o !== 1'b1 || PC_o !== 32'h20)
      $display("FAIL load_rd_rw_pc: got rd=%0d rw=%b pc=%h expected 3 1 20", Rd_o, RegWrite_o, PC_o); else passed++;
    // Reset while a valid instruction is presented
    rst_i = 1; MemRead_i = 1;
    tick();
    total++; if (Valid_o !== 1'b0 || RegWrite_o !== 1'b0 || MemRead_o !== 1'b0)
      $display("FAIL reset_ctrl: got v=%b rw=%b mr=%b expected 0 0 0", Valid_o, RegWrite_o, MemRead_o); else passed++;
    total++; if (ALUCtrl_o !== 5'd0 || SrcA_o !== 32'd0 || SrcB_o !== 32'd0 || WriteData_o !== 32'd0)
      $display("FAIL reset_data: got alu=%0d a=%h b=%h wd=%h expected all 0", ALUCtrl_o, SrcA_o, SrcB_o, WriteData_o); else passed++;
    total++; if (PC_o !== 32'd0 || Rd_o !== 5'd0 || LoadUseHazard_o !== 1'b0)
      $display("FAIL reset_misc: got pc=%h rd=%0d hz=%b expected 0", PC_o, Rd_o, LoadUseHazard_o); else passed++;
    clear_inputs();
  endtask

  task automatic test_forwarding();
    clear_inputs();
    Valid_i = 1; Rs1_i = 5'd5; RD1_i = 32'h11; Rs2_i = 5'd6; RD2_i = 32'h22;
    tick();
    MemRegWrite_i = 1; MemRd_i = 5'd5; MemResult_i = 32'h55;
    WbRegWrite_i = 1; WbRd_i = 5'd5; WbResult_i = 32'h77;
    #1;
    total++; if (SrcA_o !== 32'h55) $display("FAIL fwd_mem_priority: got %h expected 55", SrcA_o); else passed++;
    total++; if (SrcB_o !== 32'h22) $display("FAIL fwd_b_nomatch: got %h expected 22", SrcB_o); else passed++;
    MemRegWrite_i = 0;
    #1;
    total++; if (SrcA_o !== 32'h77) $display("FAIL fwd_wb: got %h expected 77", SrcA_o); else passed++;
    WbRegWrite_i = 0;
    #1;
    total++; if (SrcA_o !== 32'h11) $display("FAIL fwd_none: got %h expected 11", SrcA_o); else passed++;
    MemRegWrite_i = 1; MemRd_i = 5'd6; MemResult_i = 32'h66;
    #1;
    total++; if (SrcB_o !== 32'h66 || WriteData_o !== 32'h66)
      $display("FAIL fwd_b_mem: got b=%h wd=%h expected 66", SrcB_o, WriteData_o); else passed++;
    // x0 must never be forwarded
    MemRegWrite_i = 0; WbRegWrite_i = 0;
    Rs1_i = 5'd0; RD1_i = 32'h33;
    tick();
    MemRegWrite_i = 1; MemRd_i = 5'd0; MemResult_i = 32'h55;
    WbRegWrite_i = 1; WbRd_i = 5'd0; WbResult_i = 32'h77;
    #1;
    total++; if (SrcA_o !== 32'h33) $display("FAIL fwd_x0: got %h expected 33", SrcA_o); else passed++;
    clear_inputs();
  endtask

  task automatic test_load_use();
    clear_inputs();
    Valid_i = 1; MemRead_i = 1; RegWrite_i = 1; Rd_i = 5'd7; Rs1_i = 5'd1; Rs2_i = 5'd2;
    tick();
    total++; if (MemRead_o !== 1'b1 || Rd_o !== 5'd7) $display("FAIL lu_load_ex: got mr=%b rd=%0d expected 1 7", MemRead_o, Rd_o); else passed++;
    MemRead_i = 0; Rs1_i = 5'd3; Rs2_i = 5'd7; Rd_i = 5'd9; ALUCtrl_i = 5'd2;
    #1;
    total++; if (LoadUseHazard_o !== 1'b1) $display("FAIL lu_detect: got %b expected 1", LoadUseHazard_o); else passed++;
    tick();
    total++; if (Valid_o !== 1'b0 || RegWrite_o !== 1'b0 || MemRead_o !== 1'b0)
      $display("FAIL lu_bubble: got v=%b rw=%b mr=%b expected 0 0 0", Valid_o, RegWrite_o, MemRead_o); else passed++;
    total++; if (LoadUseHazard_o !== 1'b0) $display("FAIL lu_clear: got %b expected 0", LoadUseHazard_o); else passed++;
    tick();
    total++; if (Valid_o !== 1'b1 || Rd_o !== 5'd9 || ALUCtrl_o !== 5'd2)
      $display("FAIL lu_replay: got v=%b rd=%0d alu=%0d expected 1 9 2", Valid_o, Rd_o, ALUCtrl_o); else passed++;
    // Non-matching sources
    MemRead_i = 1; Rd_i = 5'd7; Rs1_i = 5'd0; Rs2_i = 5'd0;
    tick();
    MemRead_i = 0; Rs1_i = 5'd8; Rs2_i = 5'd8;
    #1;
    total++; if (LoadUseHazard_o !== 1'b0) $display("FAIL lu_nomatch: got %b expected 0", LoadUseHazard_o); else passed++;
    Rs1_i = 5'd7; Valid_i = 0;
    #1;
    total++; if (LoadUseHazard_o !== 1'b0) $display("FAIL lu_invalid_decode: got %b expected 0", LoadUseHazard_o); else passed++;
    // Stall wins the register update but the hazard still shows
    Valid_i = 1; Stall_i = 1;
    #1;
    total++; if (LoadUseHazard_o !== 1'b1) $display("FAIL lu_under_stall: got %b expected 1", LoadUseHazard_o); else passed++;
    tick();
    total++; if (Valid_o !== 1'b1 || MemRead_o !== 1'b1 || Rd_o !== 5'd7)
      $display("FAIL lu_stall_hold: got v=%b mr=%b rd=%0d expected 1 1 7", Valid_o, MemRead_o, Rd_o); else passed++;
    // A load to x0 never raises the hazard
    Stall_i = 0; Valid_i = 1; MemRead_i = 1; Rd_i = 5'd0; Rs1_i = 5'd1; Rs2_i = 5'd2;
    tick();
    MemRead_i = 0; Rs1_i = 5'd0; Rs2_i = 5'd0;
    #1;
    total++; if (LoadUseHazard_o !== 1'b0) $display("FAIL lu_x0: got %b expected 0", LoadUseHazard_o); else passed++;
    clear_inputs();
  endtask

  task automatic test_stall_flush();
    clear_inputs();
    Valid_i = 1; ALUCtrl_i = 5'd3; RD1_i = 32'h21; RegWrite_i = 1; Rd_i = 5'd4;
    tick();
    Stall_i = 1; Flush_i = 1; ALUCtrl_i = 5'd4; Rd_i = 5'd5;
    tick();
    total++; if (Valid_o !== 1'b0 || RegWrite_o !== 1'b0 || Rd_o !== 5'd0)
      $display("FAIL flush_over_stall: got v=%b rw=%b rd=%0d expected 0 0 0", Valid_o, RegWrite_o, Rd_o); else passed++;
    Stall_i = 0; Flush_i = 0;
    Valid_i = 1; ALUCtrl_i = 5'd6; RD1_i = 32'hAB; RD2_i = 32'hCD; Rd_i = 5'd12;
    RegWrite_i = 1; PC_i = 32'h40; Rs1_i = 5'd10; Rs2_i = 5'd11;
    tick();
    Stall_i = 1; ALUCtrl_i = 5'd9; RD1_i = 32'h1; RD2_i = 32'h2; Rd_i = 5'd13; PC_i = 32'h80; Valid_i = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (Valid_o !== 1'b1 || ALUCtrl_o !== 5'd6 || SrcA_o !== 32'hAB || SrcB_o !== 32'hCD ||
                   Rd_o !== 5'd12 || PC_o !== 32'h40 || RegWrite_o !== 1'b1)
        $display("FAIL stall_hold_%0d: got v=%b alu=%0d a=%h b=%h rd=%0d pc=%h rw=%b expected 1 6 ab cd 12 40 1",
                 i, Valid_o, ALUCtrl_o, SrcA_o, SrcB_o, Rd_o, PC_o, RegWrite_o); else passed++;
    end
    // Forwarding stays live on held contents
    WbRegWrite_i = 1; WbRd_i = 5'd10; WbResult_i = 32'hBEEF;
    #1;
    total++; if (SrcA_o !== 32'hBEEF) $display("FAIL stall_fwd: got %h expected beef", SrcA_o); else passed++;
    Stall_i = 0; Flush_i = 1; Valid_i = 1; RegWrite_i = 1;
    tick();
    total++; if (Valid_o !== 1'b0 || RegWrite_o !== 1'b0) $display("FAIL flush_only: got v=%b rw=%b expected 0 0", Valid_o, RegWrite_o); else passed++;
    clear_inputs();
  endtask

  task automatic test_operand_mux();
    clear_inputs();
    Valid_i = 1; ASel_i = 2'd1; PC_i = 32'h100; BSel_i = 1; ImmExt_i = 32'hFFFFFFFC;
    RD1_i = 32'h5; RD2_i = 32'd9; Rs1_i = 5'd3; Rs2_i = 5'd6;
    tick();
    WbRegWrite_i = 1; WbRd_i = 5'd6; WbResult_i = 32'h42;
    #1;
    total++; if (SrcA_o !== 32'h100) $display("FAIL mux_pc: got %h expected 100", SrcA_o); else passed++;
    total++; if (SrcB_o !== 32'hFFFFFFFC) $display("FAIL mux_imm: got %h expected fffffffc", SrcB_o); else passed++;
    total++; if (WriteData_o !== 32'h42) $display("FAIL mux_wdata_fwd: got %h expected 42", WriteData_o); else passed++;
    clear_inputs();
  endtask

  task automatic test_lui();
    clear_inputs();
    Valid_i = 1; ASel_i = 2'd2; BSel_i = 1; ImmExt_i = 32'h12345000; RD1_i = 32'h999; PC_i = 32'h44;
    tick();
    total++; if (SrcA_o !== 32'd0 || SrcB_o !== 32'h12345000)
      $display("FAIL lui: got a=%h b=%h expected 0 12345000", SrcA_o, SrcB_o); else passed++;
    ASel_i = 2'd3; BSel_i = 0; RD2_i = 32'h77;
    tick();
    total++; if (SrcA_o !== 32'd0 || SrcB_o !== 32'h77)
      $display("FAIL asel3: got a=%h b=%h expected 0 77", SrcA_o, SrcB_o); else passed++;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_forwarding();
    test_load_use();
    test_stall_flush();
    test_operand_mux();
    test_lui();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
ID/EX pipeline register and operand-forwarding stage that sits directly upstream of the ALU and drives its control code and both source operands.
- Latches decoded fields each cycle.
- Resolves RAW hazards by forwarding from the MEM and WB stages.
- Detects load-use hazards and inserts a bubble.
- Supports external stall and flush, the latter for taken branches and jumps resolved from ALU flags.

Parameters:
DATA_W, 32, datapath width
REG_AW, 5, register-index width
CTRL_W, 5, ALU control code width

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  synchronous reset, active-high
Stall_i  in  1  hold current contents; the whole pipeline freezes with it
Flush_i  in  1  replace next contents with a bubble
Valid_i  in  1  decode slot holds a real instruction
ALUCtrl_i  in  CTRL_W  decoded ALU operation code
RD1_i  in  DATA_W  register-file read data for rs1
RD2_i  in  DATA_W  register-file read data for rs2
ImmExt_i  in  DATA_W  sign-extended immediate
PC_i  in  DATA_W  instruction PC
Rs1_i  in  REG_AW  decode rs1 index; also used for hazard detection
Rs2_i  in  REG_AW  decode rs2 index; also used for hazard detection
Rd_i  in  REG_AW  destination index
ASel_i  in  2  SrcA select: 0 = forwarded rs1, 1 = PC, 2 or 3 = zero
BSel_i  in  1  SrcB select: 0 = forwarded rs2, 1 = immediate
RegWrite_i  in  1  instruction writes rd
MemRead_i  in  1  instruction is a load
MemRegWrite_i  in  1  MEM-stage instruction writes rd
MemRd_i  in  REG_AW  MEM-stage rd
MemResult_i  in  DATA_W  MEM-stage ALU result
WbRegWrite_i  in  1  WB-stage instruction writes rd
WbRd_i  in  REG_AW  WB-stage rd
WbResult_i  in  DATA_W  WB-stage final result
ALUCtrl_o  out  CTRL_W  to ALU control input
SrcA_o  out  DATA_W  to ALU operand A
SrcB_o  out  DATA_W  to ALU operand B
WriteData_o  out  DATA_W  forwarded rs2 value for stores
PC_o  out  DATA_W  registered PC, for branch target computation
Rd_o  out  REG_AW  registered rd
RegWrite_o  out  1  registered RegWrite, gated by valid
MemRead_o  out  1  registered MemRead, gated by valid
Valid_o  out  1  EX slot holds a real instruction
LoadUseHazard_o  out  1  upstream must stall fetch/decode this cycle

Behaviour:
- Reset: on rst_i=1 at a clock edge, all registered fields are cleared to 0.
  - Valid_o, RegWrite_o and MemRead_o are 0; ALUCtrl_o is 0 (add).
  - The register update is synchronous, so reset mid-stall or mid-flush is also just cleared next edge.
- Register update priority per edge: rst_i > Flush_i > Stall_i > LoadUseHazard_o > normal load.
  - Flush: Valid, RegWrite, MemRead and Rd become 0; the data fields may take any value. Flush_i overrides Stall_i.
  - Stall: all fields hold.
  - Hazard bubble: same effect as a flush. The decode instruction is not lost, because upstream holds it.
  - Normal load: all *_i fields are captured.
- Valid gating: RegWrite and MemRead are captured as RegWrite_i&Valid_i and MemRead_i&Valid_i.
- Load-use detection (combinational):
  - LoadUseHazard_o = Valid_o & MemRead_o & (Rd_o != 0) & ((Rd_o == Rs1_i) | (Rd_o == Rs2_i)) & Valid_i.
  - It is asserted regardless of Stall_i, but Stall_i still wins for the register update.
- Forwarding (combinational on the registered rs1/rs2):
  - fwdA = MemResult_i if MemRegWrite_i & MemRd_i != 0 & MemRd_i == rs1q.
  - Otherwise fwdA = WbResult_i if WbRegWrite_i & WbRd_i != 0 & WbRd_i == rs1q.
  - Otherwise fwdA = registered RD1. fwdB is the same for rs2.
  - MEM beats WB when both match. x0 is never forwarded.
- Operand muxes:
  - SrcA_o = fwdA / PC / 0 / 0 for ASel 0/1/2/3.
  - SrcB_o = BSel ? ImmExt : fwdB.
  - WriteData_o = fwdB, always, independent of BSel.
- Latency:
  - Decode fields appear on the outputs one cycle after capture.
  - Forwarding paths are zero-latency and stay active on the held contents during a stall.
- Bubbles: outputs are still driven from the held or cleared registers; consumers qualify with Valid_o.

Test Plan:
1. Reset, then load (Valid_i=1, ALUCtrl_i=1, RD1_i=10, RD2_i=3, ASel=0, BSel=0) -> next cycle ALUCtrl_o=1, SrcA_o=10, SrcB_o=3, Valid_o=1; with rst_i held, all outputs are 0.
2. rs1q=5 with MemRegWrite_i=1, MemRd_i=5, MemResult_i=0x55, and WbRd_i=5, WbResult_i=0x77 -> SrcA_o=0x55. With MemRegWrite_i=0 -> SrcA_o=0x77. With rs1q=0 and MemRd_i=0 -> SrcA_o = registered RD1.
3. EX holds a load with Rd_o=7; decode has Rs2_i=7 -> LoadUseHazard_o=1, and next cycle Valid_o=0, RegWrite_o=0. With Rs1_i=Rs2_i=8 -> LoadUseHazard_o=0.
4. Stall_i=1 and Flush_i=1 in the same cycle -> next cycle Valid_o=0. Stall_i=1 alone for 3 cycles -> all outputs unchanged.
5. ASel=1, PC_i=0x100, BSel=1, ImmExt_i=0xFFFFFFFC, RD2_i=9 with rs2 matching WB (WbResult_i=0x42) -> SrcA_o=0x100, SrcB_o=0xFFFFFFFC, WriteData_o=0x42.
6. ASel=2, ImmExt_i=0x12345000, BSel=1 (LUI) -> SrcA_o=0, SrcB_o=0x12345000.
